mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter: WAIT_CYCLES, default 1, SRAM strobe length in clk cycles (legal 1..15).
REQ-002 clk  input  1  pipeline clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 instruction_in  input  16  instruction leaving the ALU stage; bits [15:11] decoded here.
REQ-005 alu_res_in  input  16  ALU result: memory address for lw/lw_sp/sw/sw_sp, writeback value otherwise.
REQ-006 store_data_in  input  16  data to store for sw/sw_sp.
REQ-007 wb_en_in / wb_dest_in  input  1 / 4  register-write enable and destination index from upstream.
REQ-008 wb_en / wb_dest / wb_data  output  1 / 4 / 16  registered writeback bundle to the register file.
REQ-009 stall  output  1  upstream must hold all inputs unchanged while high.
REQ-010 sram_addr  output  18  {2'b00, address}.
REQ-011 sram_dq_out / sram_dq_in / sram_dq_oe  output 16 / input 16 / output 1  split data bus; top level builds the tristate.
REQ-012 sram_ce_n / sram_oe_n / sram_we_n  output  1 each  active-low SRAM strobes, all registered.

Function
REQ-013 Decode on instruction_in[15:11]: 10010 lw_sp, 10011 lw = LOAD; 11010 sw_sp, 11011 sw = STORE; everything else = PASS.
REQ-014 States: IDLE, READ, WRITE, HOLD; 4-bit wait counter.
REQ-015 PASS in IDLE: stall=0; next edge wb_data<=alu_res_in, wb_dest<=wb_dest_in, wb_en<=wb_en_in (1-cycle latency).
REQ-016 LOAD in IDLE: stall=1; next edge -> READ, sram_addr<=address, ce_n=0, oe_n=0, counter<=WAIT_CYCLES-1.
REQ-017 READ: stall=1 while counter!=0, counter decrements; stall=0 when counter==0; that edge captures sram_dq_in into wb_data, wb_en<=wb_en_in, ce_n=oe_n=1, -> IDLE.
REQ-018 Load occupancy WAIT_CYCLES+1 cycles, stall high WAIT_CYCLES cycles.
REQ-019 STORE in IDLE: stall=1; next edge -> WRITE, sram_addr, sram_dq_out<=store_data_in, dq_oe=1, ce_n=0, we_n=0.
REQ-020 WRITE: held WAIT_CYCLES cycles, stall=1; then we_n<=1 -> HOLD (address, data, dq_oe, ce_n unchanged).
REQ-021 HOLD: stall=0; next edge ce_n=1, dq_oe=0, -> IDLE; store drives wb_en=0.
REQ-022 oe_n and we_n never both low; dq_oe=1 only in WRITE/HOLD.
REQ-023 stall is combinational from state, counter and decoded op only; no path from sram_dq_in.
REQ-024 While stall=1, wb_en is 0 (bubble) for every cycle except the completing edge.
REQ-025 Address wraps naturally at 16 bits; no range check.

Reset
REQ-026 rst high: state IDLE, counter 0, ce_n=oe_n=we_n=1, dq_oe=0, sram_addr=0, sram_dq_out=0, wb_en=0, wb_dest=0, wb_data=0, stall=0.
REQ-027 rst asserted mid-access aborts immediately; bus released asynchronously, no partial writeback.
REQ-028 First edge after rst deasserts treats instruction_in as a fresh instruction.

Configuration
REQ-029 Macro MEM_STORE_FORWARD_EN: when defined, last store address/data are kept in a valid-tagged register (cleared by rst); a LOAD whose address equals it completes as PASS with the stored data, stall=0, no SRAM access.
REQ-030 Without MEM_STORE_FORWARD_EN every LOAD accesses SRAM per REQ-016..018.

Verification
REQ-031 PASS: instr 0x4901 (addiu), alu_res_in=0x1234, wb_en_in=1, wb_dest_in=1 -> next edge wb_data=0x1234, wb_en=1, stall never high.
REQ-032 LOAD, WAIT_CYCLES=1: lw addr 0x0040, SRAM returns 0xBEEF -> stall high 1 cycle, ce_n/oe_n low 1 cycle, sram_addr=0x00040, wb_data=0xBEEF after 2 edges.
REQ-033 STORE, WAIT_CYCLES=2: sw addr 0x0100 data 0xA5A5 -> we_n low exactly 2 cycles, dq_oe high 3 cycles, stall high 3 cycles, wb_en=0.
REQ-034 Reset mid-WRITE: rst at second WRITE cycle -> same instant we_n=ce_n=1, dq_oe=0, stall=0.
REQ-035 Forward (macro on): sw 0x0200=0x1111 then lw 0x0200 -> load completes in 1 cycle, wb_data=0x1111, oe_n stays 1; macro off -> normal SRAM read.
REQ-036 Back-to-back lw, sw, PASS: strobes never overlap, oe_n/we_n never both low, each result appears once.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU results through or runs one SRAM read/write per load/store.
// Optional MEM_STORE_FORWARD_EN: a load hitting the last stored address completes from a forward register.
module mem_access #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instruction_in,
  input  logic [15:0] alu_res_in,
  input  logic [15:0] store_data_in,
  input  logic        wb_en_in,
  input  logic [3:0]  wb_dest_in,
  output logic        wb_en,
  output logic [3:0]  wb_dest,
  output logic [15:0] wb_data,
  output logic        stall,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, HOLD} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d, dout_q, dout_d, wb_data_q, wb_data_d;
  logic        dq_oe_q, dq_oe_d, ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic        wb_en_q, wb_en_d;
  logic [3:0]  wb_dest_q, wb_dest_d;
  logic        stall_c, is_load, is_store, fwd_hit;
  logic [15:0] fwd_val;
  logic        unused_ok;

  assign unused_ok = ^instruction_in[10:0];
  assign is_load   = (instruction_in[15:11] == 5'b10010) || (instruction_in[15:11] == 5'b10011);
  assign is_store  = (instruction_in[15:11] == 5'b11010) || (instruction_in[15:11] == 5'b11011);

`ifdef MEM_STORE_FORWARD_EN
  logic        fwd_vld_q;
  logic [15:0] fwd_addr_q, fwd_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_vld_q  <= 1'b0;
      fwd_addr_q <= '0;
      fwd_data_q <= '0;
    end else if (state_q == IDLE && is_store) begin
      fwd_vld_q  <= 1'b1;
      fwd_addr_q <= alu_res_in;
      fwd_data_q <= store_data_in;
    end
  end

  assign fwd_hit = is_load && fwd_vld_q && (fwd_addr_q == alu_res_in);
  assign fwd_val = fwd_data_q;
`else
  assign fwd_hit = 1'b0;
  assign fwd_val = '0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    dq_oe_d   = dq_oe_q;
    ce_n_d    = ce_n_q;
    oe_n_d    = oe_n_q;
    we_n_d    = we_n_q;
    wb_en_d   = 1'b0;
    wb_dest_d = wb_dest_q;
    wb_data_d = wb_data_q;
    stall_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (is_load && !fwd_hit) begin
          stall_c = 1'b1;
          state_d = READ;
          addr_d  = alu_res_in;
          ce_n_d  = 1'b0;
          oe_n_d  = 1'b0;
          cnt_d   = CNT_INIT;
        end else if (is_store) begin
          stall_c = 1'b1;
          state_d = WRITE;
          addr_d  = alu_res_in;
          dout_d  = store_data_in;
          dq_oe_d = 1'b1;
          ce_n_d  = 1'b0;
          we_n_d  = 1'b0;
          cnt_d   = CNT_INIT;
        end else begin
          wb_en_d   = wb_en_in;
          wb_dest_d = wb_dest_in;
          wb_data_d = fwd_hit ? fwd_val : alu_res_in;
        end
      end
      READ: begin
        if (cnt_q != 4'd0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          wb_data_d = sram_dq_in;
          wb_en_d   = wb_en_in;
          wb_dest_d = wb_dest_in;
          ce_n_d    = 1'b1;
          oe_n_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      WRITE: begin
        stall_c = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          we_n_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Completing cycle of a store: address/data stay driven one more cycle after we_n rises.
        ce_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      dout_q    <= '0;
      dq_oe_q   <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      wb_en_q   <= 1'b0;
      wb_dest_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      dq_oe_q   <= dq_oe_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      wb_en_q   <= wb_en_d;
      wb_dest_q <= wb_dest_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Reset forces stall low even if a load/store is presented during reset.
  assign stall       = stall_c & ~rst;
  assign sram_addr   = {2'b00, addr_q};
  assign sram_dq_out = dout_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign wb_en       = wb_en_q;
  assign wb_dest     = wb_dest_q;
  assign wb_data     = wb_data_q;
endmodule

// File: tb/tb_mem_access.sv
// Directed bench: instance u1 (WAIT_CYCLES=1) and u2 (WAIT_CYCLES=2) share inputs; each test resyncs via reset.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr, alu, sdata, dq_in;
  logic        wbe_in;
  logic [3:0]  wbd_in;

  logic        wb_en1, wb_en2, stall1, stall2, doe1, doe2, ce1, ce2, oe1, oe2, we1, we2;
  logic [3:0]  wb_dest1, wb_dest2;
  logic [15:0] wb_data1, wb_data2, dout1, dout2;
  logic [17:0] addr1, addr2;

  int checks = 0;
  int errors = 0;
  int n_stall, n_we, n_doe;

  always #5 clk = ~clk;

  mem_access #(.WAIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .instruction_in(instr), .alu_res_in(alu), .store_data_in(sdata),
    .wb_en_in(wbe_in), .wb_dest_in(wbd_in), .wb_en(wb_en1), .wb_dest(wb_dest1), .wb_data(wb_data1),
    .stall(stall1), .sram_addr(addr1), .sram_dq_out(dout1), .sram_dq_in(dq_in), .sram_dq_oe(doe1),
    .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1));

  mem_access #(.WAIT_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .instruction_in(instr), .alu_res_in(alu), .store_data_in(sdata),
    .wb_en_in(wbe_in), .wb_dest_in(wbd_in), .wb_en(wb_en2), .wb_dest(wb_dest2), .wb_data(wb_data2),
    .stall(stall2), .sram_addr(addr2), .sram_dq_out(dout2), .sram_dq_in(dq_in), .sram_dq_oe(doe2),
    .sram_ce_n(ce2), .sram_oe_n(oe2), .sram_we_n(we2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  task automatic nop();
    instr = 16'h0000; alu = 16'h0000; wbe_in = 1'b0; wbd_in = 4'd0;
  endtask

  // Bus-protocol monitor: oe_n/we_n never both low, data bus driven only while oe_n is high.
  always @(negedge clk) begin
    if (!rst) begin
      chk("u1_oe_we_excl", 32'(oe1 | we1), 32'd1);
      chk("u2_oe_we_excl", 32'(oe2 | we2), 32'd1);
      chk("u2_doe_vs_oe", 32'(doe2 & ~oe2), 32'd0);
    end
  end

  initial begin
    rst = 1'b1; sdata = '0; dq_in = 16'hBEEF;
    nop();
    #2;
    chk("rst_wb_en", 32'(wb_en1), 32'd0);
    chk("rst_wb_data", 32'(wb_data1), 32'd0);
    chk("rst_wb_dest", 32'(wb_dest2), 32'd0);
    chk("rst_strobes", 32'({ce1, oe1, we1, doe1}), 32'hE);
    chk("rst_addr", 32'(addr2), 32'd0);
    chk("rst_dout", 32'(dout2), 32'd0);
    instr = 16'h9800;
    #1;
    chk("rst_stall_forced0", 32'(stall1), 32'd0);
    nop();
    tick();
    rst = 1'b0;

    // PASS: addiu
    instr = 16'h4901; alu = 16'h1234; wbe_in = 1'b1; wbd_in = 4'd1;
    #1;
    chk("pass_stall", 32'({stall1, stall2}), 32'd0);
    tick();
    chk("pass_wb_data", 32'(wb_data1), 32'h1234);
    chk("pass_wb_en", 32'(wb_en1), 32'd1);
    chk("pass_wb_dest", 32'(wb_dest1), 32'd1);
    chk("pass_u2_wb_data", 32'(wb_data2), 32'h1234);

    // LOAD on u1 (WAIT_CYCLES=1)
    do_reset();
    instr = 16'h9800; alu = 16'h0040; wbe_in = 1'b1; wbd_in = 4'd3;
    #1;
    chk("ld_stall_c0", 32'(stall1), 32'd1);
    tick();
    chk("ld_addr", 32'(addr1), 32'h00040);
    chk("ld_ce_oe_low", 32'({ce1, oe1, we1}), 32'b001);
    chk("ld_stall_c1", 32'(stall1), 32'd0);
    chk("ld_bubble", 32'(wb_en1), 32'd0);
    tick();
    nop();
    chk("ld_wb_data", 32'(wb_data1), 32'hBEEF);
    chk("ld_wb_en", 32'(wb_en1), 32'd1);
    chk("ld_wb_dest", 32'(wb_dest1), 32'd3);
    chk("ld_release", 32'({ce1, oe1}), 32'b11);

    // STORE on u2 (WAIT_CYCLES=2)
    do_reset();
    instr = 16'hD800; alu = 16'h0100; sdata = 16'hA5A5; wbe_in = 1'b1; wbd_in = 4'd4;
    n_stall = 0; n_we = 0; n_doe = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_stall += int'(stall2);
      n_we    += int'(!we2);
      n_doe   += int'(doe2);
      chk("st_no_wb", 32'(wb_en2), 32'd0);
      if (i == 1) begin
        chk("st_addr", 32'(addr2), 32'h00100);
        chk("st_dout", 32'(dout2), 32'hA5A5);
        chk("st_ce", 32'(ce2), 32'd0);
      end
      tick();
    end
    nop();
    chk("st_stall_cycles", 32'(n_stall), 32'd3);
    chk("st_we_cycles", 32'(n_we), 32'd2);
    chk("st_doe_cycles", 32'(n_doe), 32'd3);
    chk("st_end_bus", 32'({doe2, ce2, we2, wb_en2}), 32'b0110);

    // Reset during the second WRITE cycle
    do_reset();
    instr = 16'hD800; alu = 16'h0100; sdata = 16'h5A5A; wbe_in = 1'b1;
    tick();
    tick();
    chk("rw_in_write", 32'({we2, doe2}), 32'b01);
    rst = 1'b1;
    #1;
    chk("rw_abort_bus", 32'({we2, ce2, doe2}), 32'b110);
    chk("rw_abort_stall", 32'(stall2), 32'd0);
    chk("rw_no_wb", 32'(wb_en2), 32'd0);
    nop();
    tick();
    rst = 1'b0;

    // sw 0x0200 = 0x1111, then lw 0x0200, then PASS, on u2
    do_reset();
    instr = 16'hD800; alu = 16'h0200; sdata = 16'h1111; wbe_in = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    instr = 16'h9800; alu = 16'h0200; wbe_in = 1'b1; wbd_in = 4'd5; dq_in = 16'hBEEF;
    #1;
`ifdef MEM_STORE_FORWARD_EN
    chk("fw_stall", 32'(stall2), 32'd0);
    tick();
    chk("fw_oe_n", 32'(oe2), 32'd1);
    chk("fw_wb_data", 32'(wb_data2), 32'h1111);
    chk("fw_wb_en", 32'(wb_en2), 32'd1);
`else
    chk("nf_stall_c0", 32'(stall2), 32'd1);
    tick();
    chk("nf_oe_n", 32'(oe2), 32'd0);
    chk("nf_addr", 32'(addr2), 32'h00200);
    chk("nf_stall_c1", 32'(stall2), 32'd1);
    tick();
    chk("nf_stall_c2", 32'(stall2), 32'd0);
    tick();
    chk("nf_wb_data", 32'(wb_data2), 32'hBEEF);
    chk("nf_wb_en", 32'(wb_en2), 32'd1);
    chk("nf_oe_release", 32'(oe2), 32'd1);
`endif
    chk("ld_wb_dest5", 32'(wb_dest2), 32'd5);
    instr = 16'h4901; alu = 16'h5555; wbe_in = 1'b1; wbd_in = 4'd2;
    #1;
    chk("b2b_pass_stall", 32'(stall2), 32'd0);
    tick();
    nop();
    chk("b2b_pass_data", 32'(wb_data2), 32'h5555);
    chk("b2b_pass_dest", 32'(wb_dest2), 32'd2);
    tick();
    chk("b2b_once", 32'(wb_en2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
